// File: rtl/rope_step_sequencer.sv
// rope_step_sequencer: per-frame controller for a chain of Verlet rope nodes.
// Each frame it sends one integration pulse to every node, then runs ITERS
// constraint passes. Each pass pins node 0 to the anchor, limits every later node
// to +/-SEG per axis from its already-corrected predecessor, and finally clamps
// the result to a bounding box. Positions are signed Q19.13 in 32 bits.
//
// Ports:
//   clk                  clock
//   reset                asynchronous active-low reset
//   frame_start          one-cycle request to run a frame (honoured in IDLE only)
//   node_x_bus           node k x_pos at bits [32k+31:32k]
//   node_y_bus           node k y_pos, same packing
//   node_finish          finish flag from each node
//   verlet_state         integration pulse broadcast to all nodes
//   fix_constraint_state one-hot per-node strobe for the corrected position
//   x_fix_constraint     shared corrected x (valid while the strobe is high)
//   y_fix_constraint     shared corrected y
//   busy                 high from leaving IDLE until returning to IDLE
//   frame_done           one-cycle pulse at the end of a frame
module rope_step_sequencer #(
  parameter int unsigned NUM_NODES = 4,
  parameter int unsigned ITERS     = 2,
  parameter logic [31:0] ANCHOR_X  = 32'h0019_0000,
  parameter logic [31:0] ANCHOR_Y  = 32'h0000_0000,
  parameter logic [31:0] SEG       = 32'h0001_4000,
  parameter logic [31:0] X_MIN     = 32'h0000_0000,
  parameter logic [31:0] X_MAX     = 32'h0032_0000,
  parameter logic [31:0] Y_MIN     = 32'hFF38_0000,
  parameter logic [31:0] Y_MAX     = 32'h0032_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  input  logic [32*NUM_NODES-1:0] node_x_bus,
  input  logic [32*NUM_NODES-1:0] node_y_bus,
  input  logic [NUM_NODES-1:0]    node_finish,
  output logic                    verlet_state,
  output logic [NUM_NODES-1:0]    fix_constraint_state,
  output logic [31:0]             x_fix_constraint,
  output logic [31:0]             y_fix_constraint,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned KW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [KW-1:0] LastNode = KW'(NUM_NODES - 1);
  localparam logic [3:0]    LastIter = 4'(ITERS - 1);

  typedef enum logic [2:0] {
    StIdle, StVerlet, StWaitV, StLoad, StWrite, StWaitC, StDone
  } state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic [3:0]    iter_q;
  logic [31:0]   prev_x_q, prev_y_q;
  logic [31:0]   cx, cy;

  logic [31:0] node_x [NUM_NODES];
  logic [31:0] node_y [NUM_NODES];

  for (genvar i = 0; i < NUM_NODES; i++) begin : g_unpack
    assign node_x[i] = node_x_bus[32*i +: 32];
    assign node_y[i] = node_y_bus[32*i +: 32];
  end

  // Collapse a 33-bit signed sum back to 32 bits, saturating on overflow.
  function automatic logic [31:0] sat33(input logic [32:0] v);
    if (v[32] != v[31]) return v[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return v[31:0];
  endfunction

  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lo,
                                        input logic [31:0] hi);
    if ($signed(v) < $signed(lo)) return lo;
    if ($signed(v) > $signed(hi)) return hi;
    return v;
  endfunction

  // Segment limit around the predecessor first, then the box, so the box wins.
  function automatic logic [31:0] correct(input logic [31:0] p, input logic [31:0] v,
                                          input logic [31:0] bmin, input logic [31:0] bmax);
    logic [32:0] lo33;
    logic [32:0] hi33;
    lo33 = {p[31], p} - {SEG[31], SEG};
    hi33 = {p[31], p} + {SEG[31], SEG};
    return clamp(clamp(v, sat33(lo33), sat33(hi33)), bmin, bmax);
  endfunction

  always_comb begin
    cx = ANCHOR_X;
    cy = ANCHOR_Y;
    if (k_q != '0) begin
      cx = correct(prev_x_q, node_x[k_q], X_MIN, X_MAX);
      cy = correct(prev_y_q, node_y[k_q], Y_MIN, Y_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= StIdle;
      k_q                  <= '0;
      iter_q               <= '0;
      prev_x_q             <= '0;
      prev_y_q             <= '0;
      verlet_state         <= 1'b0;
      fix_constraint_state <= '0;
      x_fix_constraint     <= '0;
      y_fix_constraint     <= '0;
      busy                 <= 1'b0;
      frame_done           <= 1'b0;
    end else begin
      // Strobes default low; each is raised only on entry to its state.
      verlet_state         <= 1'b0;
      fix_constraint_state <= '0;
      frame_done           <= 1'b0;
      case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q      <= StVerlet;
            verlet_state <= 1'b1;
            busy         <= 1'b1;
          end
        end
        StVerlet: state_q <= StWaitV;
        StWaitV: begin
          if (&node_finish) begin
            k_q     <= '0;
            iter_q  <= '0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          x_fix_constraint     <= cx;
          y_fix_constraint     <= cy;
          fix_constraint_state <= NUM_NODES'(1) << k_q;
          state_q              <= StWrite;
        end
        StWrite: begin
          prev_x_q <= x_fix_constraint;
          prev_y_q <= y_fix_constraint;
          state_q  <= StWaitC;
        end
        StWaitC: begin
          if (node_finish[k_q]) begin
            if (k_q != LastNode) begin
              k_q     <= k_q + 1'b1;
              state_q <= StLoad;
            end else if (iter_q != LastIter) begin
              iter_q  <= iter_q + 1'b1;
              k_q     <= '0;
              state_q <= StLoad;
            end else begin
              state_q    <= StDone;
              frame_done <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rope_step_sequencer.sv
// Directed bench for rope_step_sequencer: a default-parameter instance plus a
// second instance with a huge SEG so the saturating segment limit and the box
// clamp are both exercised. Simple node models answer finish one cycle after
// their strobe; node 2 of the main instance can be made to stall once per frame.
module tb_rope_step_sequencer;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             frame_start = 1'b0;
  logic [32*N-1:0]  nxb = '0;
  logic [32*N-1:0]  nyb = '0;
  logic [N-1:0]     fin1 = '0;
  logic [N-1:0]     fin2 = '0;
  logic             vs1, vs2, busy1, busy2, done1, done2;
  logic [N-1:0]     fcs1, fcs2;
  logic [31:0]      fx1, fy1, fx2, fy2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rope_step_sequencer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .node_x_bus(nxb), .node_y_bus(nyb), .node_finish(fin1),
    .verlet_state(vs1), .fix_constraint_state(fcs1),
    .x_fix_constraint(fx1), .y_fix_constraint(fy1),
    .busy(busy1), .frame_done(done1)
  );

  rope_step_sequencer #(.SEG(32'h7FFF_FFFF)) dut2 (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .node_x_bus(nxb), .node_y_bus(nyb), .node_finish(fin2),
    .verlet_state(vs2), .fix_constraint_state(fcs2),
    .x_fix_constraint(fx2), .y_fix_constraint(fy2),
    .busy(busy2), .frame_done(done2)
  );

  // Node model for the main instance, with an optional one-shot stall.
  int   stall_cycles = 0;
  int   stall_node = 2;
  logic stall_used = 1'b0;
  int   stall_cnt = 0;
  always @(posedge clk) begin
    fin1 <= '0;
    if (vs1) begin
      fin1       <= '1;
      stall_used <= 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (fcs1[i]) begin
        if (i == stall_node && stall_cycles != 0 && !stall_used) begin
          stall_cnt  <= stall_cycles;
          stall_used <= 1'b1;
        end else begin
          fin1[i] <= 1'b1;
        end
      end
    end
    if (stall_cnt != 0) begin
      stall_cnt <= stall_cnt - 1;
      if (stall_cnt == 1) fin1[stall_node] <= 1'b1;
    end
  end

  always @(posedge clk) fin2 <= vs2 ? '1 : fcs2;

  // Per-frame trace.
  logic [N-1:0] wr_fcs [16];
  logic [31:0]  wr_x [16];
  logic [31:0]  wr_y [16];
  int           wr_cyc [16];
  logic [31:0]  w2_x [16];
  logic [31:0]  w2_y [16];
  int n_wr, n_wr2, verlet_cnt, verlet_cyc, done_cyc, done_cnt, done2_cyc;
  int overlap, busy_bad, busy_late;

  // Frame A expectations (both passes identical).
  logic [31:0] ax [4] = '{32'h0019_0000, 32'h0019_0000, 32'h0019_A000, 32'h0018_6000};
  logic [31:0] ay [4] = '{32'h0000_0000, 32'hFFFE_C000, 32'hFFFE_8000, 32'hFFFF_0000};
  // Frame B expectations, main and wide-SEG instances.
  logic [31:0] bx [4] = '{32'h0019_0000, 32'h001A_4000, 32'h001B_8000, 32'h001C_C000};
  logic [31:0] by [4] = '{32'h0000_0000, 32'hFFFE_C000, 32'hFFFD_8000, 32'hFFFC_4000};
  logic [31:0] b2x [4] = '{32'h0019_0000, 32'h0032_0000, 32'h0032_0000, 32'h0032_0000};
  logic [31:0] b2y [4] = '{32'h0000_0000, 32'hFF38_0000, 32'hFF38_0000, 32'hFF38_0000};

  task automatic set_node(input int k, input logic [31:0] x, input logic [31:0] y);
    nxb[32*k +: 32] = x;
    nyb[32*k +: 32] = y;
  endtask

  task automatic set_frame_a();
    set_node(0, 32'h0000_A000, 32'hFFFF_A000);  // (5.0, -3.0)
    set_node(1, 32'h0019_0000, 32'hFFFC_E000);  // (200.0, -25.0)
    set_node(2, 32'h0019_A000, 32'hFFFE_8000);  // (205.0, -12.0)
    set_node(3, 32'hFFF9_C000, 32'hFFFF_0000);  // (-50.0, -8.0)
  endtask

  // Pulse frame_start (cycle 0) and trace until a few cycles past frame_done.
  task automatic run_frame(input int pulse_cyc);
    n_wr = 0; n_wr2 = 0; verlet_cnt = 0; verlet_cyc = -1; done_cyc = -1; done_cnt = 0;
    done2_cyc = -1; overlap = 0; busy_bad = 0; busy_late = 0;
    @(negedge clk);
    frame_start = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      frame_start = (c == pulse_cyc);
      if (vs1) begin
        verlet_cnt++;
        verlet_cyc = c;
      end
      if (vs1 && fcs1 != '0) overlap++;
      if (fcs1 != '0 && n_wr < 16) begin
        wr_fcs[n_wr] = fcs1; wr_x[n_wr] = fx1; wr_y[n_wr] = fy1; wr_cyc[n_wr] = c;
        n_wr++;
      end
      if (fcs2 != '0 && n_wr2 < 16) begin
        w2_x[n_wr2] = fx2; w2_y[n_wr2] = fy2;
        n_wr2++;
      end
      if (done1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done2 && done2_cyc < 0) done2_cyc = c;
      if ((done_cyc < 0 || c == done_cyc) && !busy1) busy_bad++;
      if (done_cyc >= 0 && c > done_cyc && busy1) busy_late++;
      if (done_cyc >= 0 && done2_cyc >= 0 && c >= done_cyc + 3) break;
    end
    frame_start = 1'b0;
  endtask

  task automatic check_frame_a(input string tag, input int exp_done);
    n_cmp++;
    if (done_cyc !== exp_done) begin
      n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc, exp_done);
    end
    n_cmp++;
    if (n_wr !== 8) begin
      n_fail++; $display("FAIL %s write_count: got %0d want 8", tag, n_wr);
    end
    for (int i = 0; i < 8 && i < n_wr; i++) begin
      n_cmp++;
      if (wr_fcs[i] !== 4'(1 << (i % 4)) || wr_x[i] !== ax[i % 4] || wr_y[i] !== ay[i % 4])
      begin
        n_fail++;
        $display("FAIL %s write%0d: got fcs=%b x=%h y=%h want fcs=%b x=%h y=%h", tag, i,
                 wr_fcs[i], wr_x[i], wr_y[i], 4'(1 << (i % 4)), ax[i % 4], ay[i % 4]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({vs1, fcs1, fx1, fy1, busy1, done1} !== '0) begin
      n_fail++; $display("FAIL reset_held outputs: got %b %b %h %h %b %b want all 0",
                         vs1, fcs1, fx1, fy1, busy1, done1);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({vs1, fcs1, fx1, fy1, busy1, done1} !== '0) begin
      n_fail++; $display("FAIL reset_released outputs: got %b %b %h %h %b %b want all 0",
                         vs1, fcs1, fx1, fy1, busy1, done1);
    end
  endtask

  task automatic test_pin_and_segment();
    set_frame_a();
    run_frame(0);
    n_cmp++;
    if (verlet_cnt !== 1 || verlet_cyc !== 1) begin
      n_fail++; $display("FAIL verlet_pulse: got count=%0d cycle=%0d want count=1 cycle=1",
                         verlet_cnt, verlet_cyc);
    end
    n_cmp++;
    if (busy_bad !== 0 || busy_late !== 0) begin
      n_fail++; $display("FAIL busy_window: got low=%0d late=%0d want 0 0", busy_bad, busy_late);
    end
    n_cmp++;
    if (overlap !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL strobes: got overlap=%0d dones=%0d want 0 1", overlap, done_cnt);
    end
    n_cmp++;
    if (wr_cyc[0] !== 4 || wr_cyc[7] !== 25) begin
      n_fail++; $display("FAIL write_timing: got %0d %0d want 4 25", wr_cyc[0], wr_cyc[7]);
    end
    check_frame_a("frame_a", 27);
  endtask

  task automatic test_chain_box();
    set_node(0, 32'h0000_0000, 32'h0000_0000);
    for (int k = 1; k < N; k++) set_node(k, 32'h0034_0000, 32'h8000_0000);
    run_frame(0);
    n_cmp++;
    if (n_wr !== 8 || n_wr2 !== 8) begin
      n_fail++; $display("FAIL chain_write_count: got %0d %0d want 8 8", n_wr, n_wr2);
    end
    for (int i = 0; i < 8 && i < n_wr; i++) begin
      n_cmp++;
      if (wr_x[i] !== bx[i % 4] || wr_y[i] !== by[i % 4]) begin
        n_fail++; $display("FAIL chain%0d: got x=%h y=%h want x=%h y=%h", i, wr_x[i], wr_y[i],
                           bx[i % 4], by[i % 4]);
      end
    end
    for (int i = 0; i < 8 && i < n_wr2; i++) begin
      n_cmp++;
      if (w2_x[i] !== b2x[i % 4] || w2_y[i] !== b2y[i % 4]) begin
        n_fail++; $display("FAIL saturate_box%0d: got x=%h y=%h want x=%h y=%h", i, w2_x[i],
                           w2_y[i], b2x[i % 4], b2y[i % 4]);
      end
    end
  endtask

  task automatic test_handshake_stretch();
    set_frame_a();
    stall_cycles = 5;
    run_frame(10);
    stall_cycles = 0;
    n_cmp++;
    if (wr_cyc[2] !== 10 || wr_cyc[3] !== 18 || wr_cyc[7] !== 30) begin
      n_fail++; $display("FAIL stall_timing: got %0d %0d %0d want 10 18 30",
                         wr_cyc[2], wr_cyc[3], wr_cyc[7]);
    end
    n_cmp++;
    if (done_cnt !== 1 || busy_late !== 0 || busy_bad !== 0) begin
      n_fail++; $display("FAIL stall_ignore_start: got dones=%0d late=%0d low=%0d want 1 0 0",
                         done_cnt, busy_late, busy_bad);
    end
    check_frame_a("stall", 32);
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    set_frame_a();
    @(negedge clk);
    frame_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
    end
    n_cmp++;
    if (fcs1 !== 4'b0100) begin
      n_fail++; $display("FAIL midreset_precondition: got fcs=%b want 0100", fcs1);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({vs1, fcs1, fx1, fy1, busy1, done1} !== '0) begin
      n_fail++; $display("FAIL midreset_async: got %b %b %h %h %b %b want all 0",
                         vs1, fcs1, fx1, fy1, busy1, done1);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done1 || busy1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL midreset_no_done: got %0d active cycles want 0", seen);
    end
    run_frame(0);
    check_frame_a("after_reset", 27);
  endtask

  initial begin
    test_reset();
    test_pin_and_segment();
    test_chain_box();
    test_handshake_stretch();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
